retire_rat: RTL and testbench

Parametrised retirement register alias table for the backend commit stage. It accepts up to COMMIT_WIDTH retiring instructions per cycle from the reorder buffer and records each committed arch→phys destination mapping. For every committed destination it frees the physical register that was previously mapped, buffering those frees in an internal FIFO that drains to the free register list under backpressure. On a pipeline flush it exposes the full committed map so the front-end RAT can restore from it.

---
 rtl/retire_rat.sv | 126 ++++++++++++
 tb/tb_retire_rat.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_rat.sv
// Retirement register alias table: records committed arch->phys mappings and
// queues the superseded physical registers in a free FIFO toward the free list.
module retire_rat #(
    parameter int unsigned COMMIT_WIDTH  = 2,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned FREE_DEPTH    = 8,
    localparam int unsigned PW           = $clog2(NUM_PHYS_REGS),
    localparam int unsigned AW           = $clog2(NUM_ARCH_REGS)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [COMMIT_WIDTH-1:0]                i_commit_valid,
    input  logic [COMMIT_WIDTH-1:0]                i_commit_has_dest,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]        i_commit_arch_dst,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]        i_commit_phys_dst,
    output logic                                   o_commit_ready,
    output logic [COMMIT_WIDTH-1:0]                o_free_valid,
    output logic [COMMIT_WIDTH-1:0][PW-1:0]        o_free_preg,
    input  logic                                   i_free_ready,
    input  logic                                   i_flush,
    output logic                                   o_recover_valid,
    output logic [NUM_ARCH_REGS-1:0][PW-1:0]       o_rrat_map_out
);

    localparam int unsigned CNT_W = $clog2(FREE_DEPTH + 1);
    localparam int unsigned PTR_W = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;

    // Pointer advance modulo FREE_DEPTH; inc never exceeds FREE_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                  input int unsigned    inc);
        int unsigned sum;
        sum = 32'(ptr) + inc;
        if (sum >= FREE_DEPTH) begin
            sum = sum - FREE_DEPTH;
        end
        return sum[PTR_W-1:0];
    endfunction

    logic [NUM_ARCH_REGS-1:0][PW-1:0] r_table;
    logic [NUM_ARCH_REGS-1:0][PW-1:0] w_table_next;
    logic [FREE_DEPTH-1:0][PW-1:0]    r_mem;
    logic [PTR_W-1:0]                 r_head;
    logic [PTR_W-1:0]                 r_tail;
    logic [CNT_W-1:0]                 r_count;
    logic [CNT_W-1:0]                 w_push_cnt;
    logic [CNT_W-1:0]                 w_pop_cnt;
    logic [COMMIT_WIDTH-1:0]          w_fire;
    logic [COMMIT_WIDTH-1:0][PW-1:0]  w_prev;
    logic [COMMIT_WIDTH-1:0][PW-1:0]  w_push_data;
    logic                             w_commit_ready;
    logic                             r_recover;

    // Conservative: space for a full commit group regardless of this cycle's pop.
    assign w_commit_ready = (32'(r_count) + COMMIT_WIDTH) <= FREE_DEPTH;

    always_comb begin
        int unsigned n;
        w_fire       = i_commit_valid & i_commit_has_dest & {COMMIT_WIDTH{w_commit_ready}};
        w_table_next = r_table;
        w_prev       = '0;
        w_push_data  = '0;
        n            = 0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            // Youngest older lane to the same destination overrides the table.
            w_prev[i] = r_table[i_commit_arch_dst[i]];
            for (int j = 0; j < i; j++) begin
                if (w_fire[j] && (i_commit_arch_dst[j] == i_commit_arch_dst[i])) begin
                    w_prev[i] = i_commit_phys_dst[j];
                end
            end
            if (w_fire[i]) begin
                w_table_next[i_commit_arch_dst[i]] = i_commit_phys_dst[i];
                w_push_data[n] = w_prev[i];
                n = n + 1;
            end
        end
        w_push_cnt = CNT_W'(n);
    end

    always_comb begin
        w_pop_cnt = '0;
        if (i_free_ready) begin
            w_pop_cnt = (32'(r_count) > COMMIT_WIDTH) ? CNT_W'(COMMIT_WIDTH) : r_count;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            o_free_valid[k] = 32'(r_count) > 32'(k);
            o_free_preg[k]  = o_free_valid[k] ? r_mem[ptr_add(r_head, 32'(k))] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NUM_ARCH_REGS); i++) begin
                r_table[i] <= PW'(i);
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_recover <= 1'b0;
        end else begin
            r_table   <= w_table_next;
            r_head    <= ptr_add(r_head, 32'(w_pop_cnt));
            r_tail    <= ptr_add(r_tail, 32'(w_push_cnt));
            r_count   <= r_count + w_push_cnt - w_pop_cnt;
            r_recover <= i_flush;
        end
    end

    // Storage is not reset; occupancy is tracked solely by r_count.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            if (32'(k) < 32'(w_push_cnt)) begin
                r_mem[ptr_add(r_tail, 32'(k))] <= w_push_data[k];
            end
        end
    end

    assign o_commit_ready  = w_commit_ready;
    assign o_recover_valid = r_recover;
    assign o_rrat_map_out  = r_table;

endmodule

// File: tb/tb_retire_rat.sv
// Scoreboard bench for retire_rat: expected frees and recovery events are queued
// at stimulus time and checked by an independent monitor.
module tb_retire_rat;

    localparam int NA = 32;
    localparam int PW = 6;
    localparam int AW = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            commit_valid = '0;
    logic [1:0]            commit_has_dest = '0;
    logic [1:0][AW-1:0]    commit_arch = '0;
    logic [1:0][PW-1:0]    commit_phys = '0;
    logic                  commit_ready;
    logic [1:0]            free_valid;
    logic [1:0][PW-1:0]    free_preg;
    logic                  free_ready = 1'b0;
    logic                  flush = 1'b0;
    logic                  recover_valid;
    logic [NA-1:0][PW-1:0] map;

    int total = 0;
    int bad   = 0;
    int exp_free[$];
    int exp_rec_arch[$];
    int exp_rec_phys[$];

    retire_rat #(
        .COMMIT_WIDTH (2),
        .NUM_ARCH_REGS(NA),
        .NUM_PHYS_REGS(64),
        .FREE_DEPTH   (8)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_commit_valid   (commit_valid),
        .i_commit_has_dest(commit_has_dest),
        .i_commit_arch_dst(commit_arch),
        .i_commit_phys_dst(commit_phys),
        .o_commit_ready   (commit_ready),
        .o_free_valid     (free_valid),
        .o_free_preg      (free_preg),
        .i_free_ready     (free_ready),
        .i_flush          (flush),
        .o_recover_valid  (recover_valid),
        .o_rrat_map_out   (map)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_identity(input string name);
        int m;
        m = 0;
        for (int i = 0; i < NA; i++) begin
            if (map[i] !== PW'(i)) m++;
        end
        chk(name, m, 0);
    endtask

    task automatic cmt(input logic [1:0] v, input logic [1:0] hd, input int a0, input int p0,
                       input int a1, input int p1, input logic fl);
        commit_valid    = v;
        commit_has_dest = hd;
        commit_arch[0]  = AW'(a0);
        commit_phys[0]  = PW'(p0);
        commit_arch[1]  = AW'(a1);
        commit_phys[1]  = PW'(p1);
        flush           = fl;
        @(posedge clk);
        #1;
        commit_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 40 && exp_free.size() != 0; c++) @(posedge clk);
        #1;
        chk(name, exp_free.size(), 0);
    endtask

    // Monitor: a free lane is consumed when it is valid while free_ready is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (free_ready) begin
                for (int k = 0; k < 2; k++) begin
                    if (free_valid[k]) begin
                        if (exp_free.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL free_unexpected: got %0d expected none", free_preg[k]);
                        end else begin
                            chk("free_preg", free_preg[k], exp_free.pop_front());
                        end
                    end
                end
            end
            if (recover_valid) begin
                if (exp_rec_arch.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL recover_unexpected: got 1 expected 0");
                end else begin
                    chk("recover_map", map[exp_rec_arch.pop_front()], exp_rec_phys.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_free_valid", free_valid, 0);
        chk("rst_free_preg", free_preg, 0);
        chk("rst_ready", commit_ready, 1);
        chk("rst_recover", recover_valid, 0);
        chk_identity("rst_map");
        rst_n      = 1'b1;
        free_ready = 1'b1;
        @(posedge clk);
        #1;

        exp_free.push_back(3);
        cmt(2'b01, 2'b01, 3, 40, 0, 0, 1'b0);
        chk("t1_map3", map[3], 40);
        chk("t1_free_valid", free_valid, 2'b01);

        exp_free.push_back(5);
        exp_free.push_back(41);
        cmt(2'b11, 2'b11, 5, 41, 5, 42, 1'b0);
        chk("t2_map5", map[5], 42);
        chk("t2_free_valid", free_valid, 2'b11);

        exp_free.push_back(7);
        cmt(2'b11, 2'b10, 4, 33, 7, 50, 1'b0);
        chk("t3_map7", map[7], 50);
        chk("t3_map4", map[4], 4);
        chk("t3_free_valid", free_valid, 2'b01);

        exp_free.push_back(40);
        cmt(2'b10, 2'b10, 0, 0, 3, 46, 1'b0);
        chk("t4_map3", map[3], 46);
        wait_drain("drain1");

        free_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_free.push_back(10 + 2 * c);
            exp_free.push_back(11 + 2 * c);
            cmt(2'b11, 2'b11, 10 + 2 * c, 20 + 2 * c, 11 + 2 * c, 21 + 2 * c, 1'b0);
            if (c < 3) chk("bp_ready_open", commit_ready, 1);
        end
        chk("bp_ready_full", commit_ready, 0);
        chk("bp_free_valid", free_valid, 2'b11);
        chk("bp_map17", map[17], 27);
        commit_valid    = 2'b01;
        commit_has_dest = 2'b01;
        commit_arch[0]  = AW'(18);
        commit_phys[0]  = PW'(30);
        @(posedge clk);
        #1;
        chk("bp_no_accept", map[18], 18);
        chk("bp_preg_stable0", free_preg[0], 10);
        chk("bp_preg_stable1", free_preg[1], 11);
        free_ready = 1'b1;
        chk("bp_full_ready_low", commit_ready, 0);
        @(posedge clk);
        #1;
        commit_valid = '0;
        chk("bp_no_accept2", map[18], 18);
        chk("bp_ready_back", commit_ready, 1);
        wait_drain("drain_bp");

        exp_free.push_back(2);
        exp_rec_arch.push_back(2);
        exp_rec_phys.push_back(60);
        cmt(2'b01, 2'b01, 2, 60, 0, 0, 1'b1);
        chk("fl_recover", recover_valid, 1);
        chk("fl_map2", map[2], 60);
        @(posedge clk);
        #1;
        chk("fl_recover_drop", recover_valid, 0);

        for (int c = 0; c < 2; c++) begin
            exp_rec_arch.push_back(2);
            exp_rec_phys.push_back(60);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_first", recover_valid, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("b2b_second", recover_valid, 1);
        @(posedge clk);
        #1;
        chk("b2b_drop", recover_valid, 0);
        wait_drain("drain_fl");

        free_ready = 1'b0;
        cmt(2'b11, 2'b11, 20, 50, 21, 51, 1'b0);
        cmt(2'b11, 2'b11, 22, 52, 23, 53, 1'b0);
        cmt(2'b01, 2'b01, 24, 54, 0, 0, 1'b0);
        chk("pre_rst_free_valid", free_valid, 2'b11);
        chk("pre_rst_map24", map[24], 54);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_free_valid", free_valid, 0);
        chk("rst2_ready", commit_ready, 1);
        chk("rst2_recover", recover_valid, 0);
        chk_identity("rst2_map");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        free_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_free_valid", free_valid, 0);
        chk("post_rst_ready", commit_ready, 1);

        chk("rec_queue_empty", exp_rec_arch.size(), 0);
        chk("free_queue_empty", exp_free.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
